gtpe2_drp_master: RTL and testbench
===================================

Name: gtpe2_drp_master

Overview:
DRP initiator that drives the DRP slave port of the GTPE2 common/channel models (DRPEN/DRPWE/DRPADDR/DRPDI out, DRPRDY/DRPDO in) on behalf of fabric control logic. It accepts single read, write or read-modify-write (RMW) requests over a valid/ready interface and enforces the one-outstanding-access DRP rule. It returns read data or a timeout status over a valid/ready response interface. It sits between the liteeth PHY control/CSR logic and the GTPE2 DRP ports, in the DRPCLK domain.

Parameters:
- ADDR_W, 8, DRPADDR width.
- DATA_W, 16, DRPDI/DRPDO width.
- TIMEOUT_CYCLES, 64, DRPCLK cycles to wait for DRPRDY after DRPEN before aborting. Legal range 2..255.

Ports:
- DRPCLK  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  high only in IDLE.
- REQ_WE  in  1  0 = read, 1 = write.
- REQ_RMW  in  1  with REQ_WE=1: read, merge, then write.
- REQ_ADDR  in  ADDR_W  register address.
- REQ_DATA  in  DATA_W  write data.
- REQ_MASK  in  DATA_W  RMW bit-select; 1 = take REQ_DATA bit.
- RSP_VALID  out  1  response held until accepted.
- RSP_READY  in  1  response accepted.
- RSP_DATA  out  DATA_W  read data, or value written.
- RSP_TIMEOUT  out  1  DRPRDY never arrived.
- DRPEN  out  1  one-cycle access strobe.
- DRPWE  out  1  write qualifier; only high together with DRPEN.
- DRPADDR  out  ADDR_W  held stable from DRPEN until DRPRDY.
- DRPDI  out  DATA_W  write data.
- DRPRDY  in  1  slave completion, one-cycle pulse.
- DRPDO  in  DATA_W  read data, valid when DRPRDY=1.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0 except REQ_READY=1. State IDLE, timeout counter 0. Reset asserted mid-transaction aborts immediately: DRPEN drops asynchronously and no response is produced.
- All DRP outputs are registered. The request is latched on REQ_VALID&&REQ_READY (cycle T).
- States:
  - IDLE: on accept, go to RD_ISSUE if REQ_WE=0 or REQ_RMW=1; otherwise go to WR_ISSUE.
  - RD_ISSUE: DRPEN=1, DRPWE=0 for exactly one cycle (T+1); then RD_WAIT.
  - RD_WAIT: on DRPRDY, capture DRPDO. A plain read goes to RESP. An RMW computes merged = (DRPDO & ~MASK) | (DATA & MASK) and goes to WR_ISSUE.
  - WR_ISSUE: DRPEN=1, DRPWE=1, DRPDI = data or merged, for one cycle; then WR_WAIT.
  - WR_WAIT: on DRPRDY, go to RESP with RSP_DATA = value written.
  - RESP: RSP_VALID=1 with stable data. On RSP_READY go to IDLE. REQ_READY rises the following cycle.
- Latency against a slave answering DRPRDY one cycle after DRPEN: plain read/write RSP_VALID at T+3; RMW at T+5.
- Timeout: the counter clears on DRPEN and increments each cycle in RD_WAIT/WR_WAIT. When it reaches TIMEOUT_CYCLES with no DRPRDY, go to RESP with RSP_TIMEOUT=1 and RSP_DATA=0. An RMW read timeout skips the write.
- DRPRDY in the same cycle the counter expires counts as success.
- DRPRDY seen outside the WAIT states is ignored.
- Never more than one DRPEN outstanding. DRPEN never asserts in two consecutive cycles.
- DRPADDR and DRPDI hold their last driven value in IDLE.

Decomposition:
- Shared package gtpe2_drp_pkg holds:
  - state enum (IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP, one-hot);
  - DRP register address constants 0x00–0x06 for the GTPE2 common map (PLL0/1 FBDIV, REFCLK_DIV, REFCLK_SEL, lock status);
  - the RMW merge function.
- One sub-module gtpe2_drp_wdog holds the timeout counter (clear, enable, expired).

Test Plan:
- Read 0x00 against a GTPE2_COMMON_DUMMY with PLL0_FBDIV=4 -> DRPEN pulse at T+1, RSP_VALID at T+3, RSP_DATA=0x0004, RSP_TIMEOUT=0.
- Both PLLs locked, read 0x06 -> RSP_DATA=0xC000.
- Write 0x10 with data 0x1234 -> single DRPEN&DRPWE cycle with DRPDI=0x1234, RSP_DATA=0x1234 at T+3.
- RMW: slave returns 0xFF00, REQ_DATA=0x00AA, MASK=0x00FF -> write DRPDI=0xFFAA, RSP_VALID at T+5.
- TIMEOUT_CYCLES=8, slave silent -> RSP_TIMEOUT=1 and RSP_DATA=0 eight cycles after DRPEN; next request is accepted normally. DRPRDY on the expiry cycle -> success.
- RESET pulsed during RD_WAIT -> DRPEN=0, RSP_VALID=0, REQ_READY=1 immediately. RSP_READY held low for 5 cycles -> RSP_DATA stable and REQ_READY=0 throughout.

Source files
------------

// File: rtl/gtpe2_drp_pkg.sv
// gtpe2_drp_pkg: shared FSM states, GTPE2 common DRP address map and RMW merge helper.
package gtpe2_drp_pkg;
  localparam int DRP_DATA_W = 16;
  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    RD_ISSUE = 6'b000010,
    RD_WAIT  = 6'b000100,
    WR_ISSUE = 6'b001000,
    WR_WAIT  = 6'b010000,
    RESP     = 6'b100000
  } drp_state_e;
  localparam logic [7:0] DRP_PLL0_FBDIV      = 8'h00;
  localparam logic [7:0] DRP_PLL1_FBDIV      = 8'h01;
  localparam logic [7:0] DRP_PLL0_REFCLK_DIV = 8'h02;
  localparam logic [7:0] DRP_PLL1_REFCLK_DIV = 8'h03;
  localparam logic [7:0] DRP_PLL0_REFCLK_SEL = 8'h04;
  localparam logic [7:0] DRP_PLL1_REFCLK_SEL = 8'h05;
  localparam logic [7:0] DRP_PLL_LOCK        = 8'h06;
  function automatic logic [DRP_DATA_W-1:0] drp_merge(
    input logic [DRP_DATA_W-1:0] rd,
    input logic [DRP_DATA_W-1:0] wr,
    input logic [DRP_DATA_W-1:0] mask
  );
    return (rd & ~mask) | (wr & mask);
  endfunction
endpackage

// File: rtl/gtpe2_drp_wdog.sv
// gtpe2_drp_wdog: counts cycles since the last DRPEN and flags when DRPRDY is overdue.
module gtpe2_drp_wdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  // cnt is 0 in the DRPEN cycle, so LIMIT-1 marks the LIMIT-th cycle of the access
  assign expired = en && cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/gtpe2_drp_master.sv
// gtpe2_drp_master: single-outstanding DRP initiator with read, write and read-modify-write
// requests, a bounded wait for DRPRDY and a held valid/ready response.
module gtpe2_drp_master
  import gtpe2_drp_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = DRP_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              DRPCLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic              REQ_RMW,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_DATA,
  input  logic [DATA_W-1:0] REQ_MASK,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_TIMEOUT,
  output logic              DRPEN,
  output logic              DRPWE,
  output logic [ADDR_W-1:0] DRPADDR,
  output logic [DATA_W-1:0] DRPDI,
  input  logic              DRPRDY,
  input  logic [DATA_W-1:0] DRPDO,
  output logic              BUSY
);
  drp_state_e state, state_n;
  logic accept, expired, timeout_n, rmw_q;
  logic [DATA_W-1:0] data_q, mask_q, merged;
  assign accept = REQ_VALID && REQ_READY;
  assign merged = DATA_W'(drp_merge(DRP_DATA_W'(DRPDO), DRP_DATA_W'(data_q), DRP_DATA_W'(mask_q)));
  gtpe2_drp_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk    (DRPCLK),
    .rst    (RESET),
    .clr    (state_n == RD_ISSUE || state_n == WR_ISSUE),
    .en     (state != IDLE && state != RESP),
    .expired(expired)
  );
  always_ff @(posedge DRPCLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n   = state;
    timeout_n = expired && !DRPRDY;
    case (state)
      IDLE:     if (accept) state_n = (!REQ_WE || REQ_RMW) ? RD_ISSUE : WR_ISSUE;
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT:  state_n = DRPRDY ? (rmw_q ? WR_ISSUE : RESP) : (expired ? RESP : RD_WAIT);
      WR_ISSUE: state_n = WR_WAIT;
      WR_WAIT:  state_n = (DRPRDY || expired) ? RESP : WR_WAIT;
      RESP:     state_n = RSP_READY ? IDLE : RESP;
      default:  state_n = IDLE;
    endcase
  end
  // every interface output is a flop loaded from the next-state decode
  always_ff @(posedge DRPCLK or posedge RESET)
    if (RESET) begin
      REQ_READY   <= 1'b1;
      RSP_VALID   <= 1'b0;
      RSP_DATA    <= '0;
      RSP_TIMEOUT <= 1'b0;
      DRPEN       <= 1'b0;
      DRPWE       <= 1'b0;
      DRPADDR     <= '0;
      DRPDI       <= '0;
      BUSY        <= 1'b0;
      rmw_q       <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
    end else begin
      REQ_READY <= state_n == IDLE;
      BUSY      <= state_n != IDLE;
      RSP_VALID <= state_n == RESP;
      DRPEN     <= state_n == RD_ISSUE || state_n == WR_ISSUE;
      DRPWE     <= state_n == WR_ISSUE;
      if (accept) begin
        DRPADDR     <= REQ_ADDR;
        data_q      <= REQ_DATA;
        mask_q      <= REQ_MASK;
        rmw_q       <= REQ_WE && REQ_RMW;
        RSP_TIMEOUT <= 1'b0;
      end
      if (state_n == WR_ISSUE) DRPDI <= (state == RD_WAIT) ? merged : REQ_DATA;
      if (state_n == RESP && state != RESP) begin
        RSP_DATA    <= timeout_n ? '0 : (state == RD_WAIT) ? DRPDO : DRPDI;
        RSP_TIMEOUT <= timeout_n;
      end
    end
endmodule

// File: tb/tb_gtpe2_drp_master.sv
// tb_gtpe2_drp_master: directed requests against a behavioural GTPE2 common DRP slave,
// expected responses queued at issue and checked on RSP_VALID.
module tb_gtpe2_drp_master;
  logic DRPCLK = 1'b0, RESET = 1'b1;
  logic REQ_VALID = 1'b0, REQ_READY, REQ_WE = 1'b0, REQ_RMW = 1'b0;
  logic [7:0] REQ_ADDR = '0;
  logic [15:0] REQ_DATA = '0, REQ_MASK = '0;
  logic RSP_VALID, RSP_READY = 1'b0, RSP_TIMEOUT;
  logic [15:0] RSP_DATA;
  logic DRPEN, DRPWE, DRPRDY, BUSY;
  logic [7:0] DRPADDR;
  logic [15:0] DRPDI, DRPDO;
  always #5 DRPCLK = ~DRPCLK;
  gtpe2_drp_master #(.ADDR_W(8), .DATA_W(16), .TIMEOUT_CYCLES(8)) dut (
    .DRPCLK(DRPCLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_RMW(REQ_RMW),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_MASK(REQ_MASK),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_TIMEOUT(RSP_TIMEOUT),
    .DRPEN(DRPEN), .DRPWE(DRPWE), .DRPADDR(DRPADDR), .DRPDI(DRPDI),
    .DRPRDY(DRPRDY), .DRPDO(DRPDO), .BUSY(BUSY)
  );
  // slave: answers slv_delay cycles after DRPEN, silent when slv_delay is 0
  logic [15:0] mem [256];
  logic [7:0] cd = '0, slv_delay = 8'd1;
  logic [15:0] rd_q = '0;
  logic stray = 1'b0;
  always @(posedge DRPCLK) begin
    if (DRPEN) begin
      cd   <= slv_delay;
      rd_q <= mem[DRPADDR];
      if (DRPWE) mem[DRPADDR] <= DRPDI;
    end else if (cd != 8'd0) cd <= cd - 8'd1;
  end
  assign DRPRDY = (cd == 8'd1) || stray;
  assign DRPDO  = rd_q;
  int n_chk = 0, n_fail = 0, cyc = 0, en_cnt = 0, last_en = 0, t_acc = 0, en0 = 0;
  logic prev_en = 1'b0;
  logic [15:0] last_di = '0;
  typedef struct { logic [15:0] data; logic to; int lat; } exp_t;
  exp_t sb[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(posedge DRPCLK) cyc <= cyc + 1;
  always @(negedge DRPCLK) begin
    if (DRPWE) chk("drpwe_qual", {31'd0, DRPEN}, 1);
    if (DRPEN) begin
      chk("drpen_gap", {31'd0, prev_en}, 0);
      en_cnt++;
      last_en = cyc;
      if (DRPWE) last_di = DRPDI;
    end
    prev_en = DRPEN;
  end
  task automatic req(input logic we, input logic rmw, input logic [7:0] a, input logic [15:0] d,
                     input logic [15:0] m, input logic [15:0] ed, input logic eto, input int elat,
                     input int hold);
    exp_t e;
    sb.push_back('{ed, eto, elat});
    @(negedge DRPCLK);
    chk("req_ready_idle", {31'd0, REQ_READY}, 1);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_RMW = rmw; REQ_ADDR = a; REQ_DATA = d; REQ_MASK = m;
    t_acc = cyc;
    en0 = en_cnt;
    @(posedge DRPCLK);
    @(negedge DRPCLK);
    REQ_VALID = 1'b0;
    for (int k = 0; k < 40 && !RSP_VALID; k++) @(negedge DRPCLK);
    e = sb.pop_front();
    if (!RSP_VALID) begin
      chk("rsp_seen", {31'd0, RSP_VALID}, 1);
      return;
    end
    chk("rsp_data", {16'd0, RSP_DATA}, {16'd0, e.data});
    chk("rsp_timeout", {31'd0, RSP_TIMEOUT}, {31'd0, e.to});
    chk("rsp_latency", cyc - t_acc, e.lat);
    repeat (hold) begin
      @(negedge DRPCLK);
      chk("hold_valid", {31'd0, RSP_VALID}, 1);
      chk("hold_data", {16'd0, RSP_DATA}, {16'd0, e.data});
      chk("hold_req_ready", {31'd0, REQ_READY}, 0);
    end
    RSP_READY = 1'b1;
    @(negedge DRPCLK);
    RSP_READY = 1'b0;
    chk("rsp_done", {31'd0, RSP_VALID}, 0);
    chk("req_ready_back", {31'd0, REQ_READY}, 1);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0]    = 16'h0004;
    mem[6]    = 16'hC000;
    mem[8'h20] = 16'hFF00;
    repeat (2) @(negedge DRPCLK);
    chk("rst_req_ready", {31'd0, REQ_READY}, 1);
    chk("rst_rsp_valid", {31'd0, RSP_VALID}, 0);
    chk("rst_drpen", {31'd0, DRPEN}, 0);
    chk("rst_busy", {31'd0, BUSY}, 0);
    RESET = 1'b0;
    req(0, 0, 8'h00, 0, 0, 16'h0004, 0, 3, 0);
    chk("rd_en_count", en_cnt - en0, 1);
    chk("rd_en_cycle", last_en - t_acc, 1);
    req(0, 0, 8'h06, 0, 0, 16'hC000, 0, 3, 0);
    req(1, 0, 8'h10, 16'h1234, 0, 16'h1234, 0, 3, 5);
    chk("wr_en_count", en_cnt - en0, 1);
    chk("wr_di", {16'd0, last_di}, 32'h1234);
    req(0, 0, 8'h10, 0, 0, 16'h1234, 0, 3, 0);
    req(1, 1, 8'h20, 16'h00AA, 16'h00FF, 16'hFFAA, 0, 5, 0);
    chk("rmw_en_count", en_cnt - en0, 2);
    chk("rmw_di", {16'd0, last_di}, 32'hFFAA);
    chk("rmw_wr_cycle", last_en - t_acc, 3);
    slv_delay = 8'd0;
    req(0, 0, 8'h00, 0, 0, 16'h0000, 1, 9, 0);
    slv_delay = 8'd1;
    req(0, 0, 8'h00, 0, 0, 16'h0004, 0, 3, 0);
    slv_delay = 8'd7;
    req(0, 0, 8'h06, 0, 0, 16'hC000, 0, 9, 0);
    slv_delay = 8'd0;
    req(1, 1, 8'h20, 16'h0055, 16'h00FF, 16'h0000, 1, 9, 0);
    chk("rmw_to_en_count", en_cnt - en0, 1);
    @(negedge DRPCLK);
    stray = 1'b1;
    @(negedge DRPCLK);
    stray = 1'b0;
    chk("stray_busy", {31'd0, BUSY}, 0);
    chk("stray_rsp", {31'd0, RSP_VALID}, 0);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_RMW = 1'b0; REQ_ADDR = 8'h00;
    @(posedge DRPCLK);
    @(negedge DRPCLK);
    REQ_VALID = 1'b0;
    chk("mid_drpen", {31'd0, DRPEN}, 1);
    @(negedge DRPCLK);
    chk("mid_busy", {31'd0, BUSY}, 1);
    #2 RESET = 1'b1;
    #1;
    chk("arst_drpen", {31'd0, DRPEN}, 0);
    chk("arst_rsp_valid", {31'd0, RSP_VALID}, 0);
    chk("arst_req_ready", {31'd0, REQ_READY}, 1);
    chk("arst_busy", {31'd0, BUSY}, 0);
    @(negedge DRPCLK);
    RESET = 1'b0;
    repeat (12) @(negedge DRPCLK);
    chk("arst_no_rsp", {31'd0, RSP_VALID}, 0);
    slv_delay = 8'd1;
    req(0, 0, 8'h06, 0, 0, 16'hC000, 0, 3, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
